// File: rtl/seg_sched_pkg.sv
// Shared encodings for the 7-segment display scheduler: grant states, edit
// field codes and the segment patterns (bit6 = a .. bit0 = g, active-high).
package seg_sched_pkg;

  typedef enum logic [1:0] {
    SRC_CLK = 2'd0,
    SRC_TMR = 2'd1,
    SRC_ALM = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    EDIT_NONE = 2'd0,
    EDIT_HOUR = 2'd1,
    EDIT_MIN  = 2'd2,
    EDIT_SEC  = 2'd3
  } edit_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to 7-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
  import seg_sched_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (bcd_i <= 4'd9) seg_o = SEG_DIGIT[bcd_i];
  end

endmodule

// File: rtl/seg_display_sched.sv
// Display scheduler: priority/hold arbitration of clock, timer and alarm,
// segment decode and blink flags. Optional SEG_SCHED_LZB_EN blanks a zero hour-tens digit.
module seg_display_sched
  import seg_sched_pkg::*;
#(
  parameter int unsigned HOLD_TICKS  = 16,
  parameter int unsigned BLINK_TICKS = 250,
  parameter int unsigned CW          = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic [23:0] clk_bcd,
  input  logic        tmr_req,
  input  logic [23:0] tmr_bcd,
  input  logic        alm_req,
  input  logic [23:0] alm_bcd,
  input  logic [1:0]  edit_field,
  output logic [6:0]  data1,
  output logic [6:0]  data2,
  output logic [6:0]  data3,
  output logic [6:0]  data4,
  output logic [6:0]  data5,
  output logic [6:0]  data6,
  output logic        h,
  output logic        m,
  output logic        s,
  output logic [1:0]  src_sel
);

  src_e          state_q, state_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [CW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [1:0]    edit_q;
  logic [23:0]   bcd_sel;
  logic [6:0]    seg [6];
  logic [41:0]   data_q, data_d;
  logic [2:0]    hms_q, hms_d;

  always_comb begin
    state_d = state_q;
    if (alm_req) begin
      state_d = SRC_ALM;
    end else begin
      case (state_q)
        SRC_CLK: if (tmr_req && hold_q == '0) state_d = SRC_TMR;
        SRC_TMR: if (!tmr_req) state_d = SRC_CLK;
        default: state_d = tmr_req ? SRC_TMR : SRC_CLK;
      endcase
    end
  end

  // A grant change reloads hold and restarts the blink phase in the same
  // cycle, so a coincident tick is discarded for both counters.
  always_comb begin
    hold_d  = hold_q;
    blink_d = blink_q;
    phase_d = phase_q;
    if (state_d != state_q) begin
      hold_d = CW'(HOLD_TICKS - 1);
    end else if (tick && hold_q != '0) begin
      hold_d = hold_q - CW'(1);
    end
    if (state_d != state_q || edit_field != edit_q) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (blink_q == CW'(BLINK_TICKS - 1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + CW'(1);
      end
    end
  end

  always_comb begin
    case (state_q)
      SRC_TMR: bcd_sel = tmr_bcd;
      SRC_ALM: bcd_sel = alm_bcd;
      default: bcd_sel = clk_bcd;
    endcase
  end

  for (genvar i = 0; i < 6; i++) begin : g_dec
    bcd_to_seg7 u_dec (
      .bcd_i (bcd_sel[23-4*i -: 4]),
      .seg_o (seg[i])
    );
  end

  always_comb begin
    data_d = '0;
    for (int unsigned i = 0; i < 6; i++) data_d[41-7*i -: 7] = seg[i];
`ifdef SEG_SCHED_LZB_EN
    if (bcd_sel[23:20] == 4'd0) data_d[41:35] = SEG_BLANK;
`endif
  end

  // Flags use the post-update phase so an edit/grant change is visible blank-free next cycle.
  always_comb begin
    hms_d = '0;
    case (state_q)
      SRC_ALM: hms_d = {3{phase_d}};
      SRC_CLK: begin
        case (edit_e'(edit_field))
          EDIT_HOUR: hms_d = {phase_d, 2'b00};
          EDIT_MIN:  hms_d = {1'b0, phase_d, 1'b0};
          EDIT_SEC:  hms_d = {2'b00, phase_d};
          default:   hms_d = '0;
        endcase
      end
      default: hms_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SRC_CLK;
      hold_q  <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      edit_q  <= '0;
      data_q  <= '0;
      hms_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      edit_q  <= edit_field;
      data_q  <= data_d;
      hms_q   <= hms_d;
    end
  end

  assign src_sel = state_q;
  assign data1   = data_q[41:35];
  assign data2   = data_q[34:28];
  assign data3   = data_q[27:21];
  assign data4   = data_q[20:14];
  assign data5   = data_q[13:7];
  assign data6   = data_q[6:0];
  assign h       = hms_q[2];
  assign m       = hms_q[1];
  assign s       = hms_q[0];

endmodule

// File: tb/tb_seg_display_sched.sv
// Scoreboard bench for seg_display_sched: a cycle model pushes expected outputs
// at each rising edge, popped and compared on the falling edge.
module tb_seg_display_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [23:0] clk_bcd = 24'h123456;
  logic        tmr_req = 1'b0;
  logic [23:0] tmr_bcd = 24'h000930;
  logic        alm_req = 1'b0;
  logic [23:0] alm_bcd = 24'h070000;
  logic [1:0]  edit_field = 2'd0;
  logic [6:0]  data1, data2, data3, data4, data5, data6;
  logic        h, m, s;
  logic [1:0]  src_sel;

  seg_display_sched #(.HOLD_TICKS(16), .BLINK_TICKS(250), .CW(9)) dut (
    .clock(clock), .reset(reset), .tick(tick), .clk_bcd(clk_bcd),
    .tmr_req(tmr_req), .tmr_bcd(tmr_bcd), .alm_req(alm_req), .alm_bcd(alm_bcd),
    .edit_field(edit_field), .data1(data1), .data2(data2), .data3(data3),
    .data4(data4), .data5(data5), .data6(data6), .h(h), .m(m), .s(s),
    .src_sel(src_sel)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  typedef struct packed {
    logic [1:0]  src;
    logic [41:0] data;
    logic [2:0]  hms;
  } exp_t;

  exp_t sb_q[$];

  int          m_st, m_hold, m_cnt;
  bit          m_ph;
  logic [1:0]  m_edit;
  logic [41:0] m_data;
  logic [2:0]  m_hms;

  always @(posedge clock) begin : model
    int nx;
    logic [23:0] b;
    exp_t e;
    if (reset) begin
      m_st = 0; m_hold = 0; m_cnt = 0; m_ph = 0; m_edit = 0;
      m_data = '0; m_hms = '0;
    end else begin
      if (alm_req)        nx = 2;
      else if (m_st != 0) nx = tmr_req ? 1 : 0;
      else                nx = (tmr_req && m_hold == 0) ? 1 : 0;
      if (nx != m_st)                 m_hold = 15;
      else if (tick && m_hold > 0)    m_hold = m_hold - 1;
      if (nx != m_st || edit_field != m_edit) begin
        m_cnt = 0; m_ph = 0;
      end else if (tick) begin
        if (m_cnt == 249) begin m_cnt = 0; m_ph = ~m_ph; end
        else m_cnt = m_cnt + 1;
      end
      b = (m_st == 2) ? alm_bcd : (m_st == 1) ? tmr_bcd : clk_bcd;
      for (int i = 0; i < 6; i++) m_data[41-7*i -: 7] = seg_of(b[23-4*i -: 4]);
`ifdef SEG_SCHED_LZB_EN
      if (b[23:20] == 4'd0) m_data[41:35] = 7'b0000000;
`endif
      if (m_st == 2)                          m_hms = {3{m_ph}};
      else if (m_st == 0 && edit_field == 1)  m_hms = {m_ph, 2'b00};
      else if (m_st == 0 && edit_field == 2)  m_hms = {1'b0, m_ph, 1'b0};
      else if (m_st == 0 && edit_field == 3)  m_hms = {2'b00, m_ph};
      else                                    m_hms = 3'b000;
      m_edit = edit_field;
      m_st = nx;
    end
    e.src = 2'(m_st);
    e.data = m_data;
    e.hms = m_hms;
    sb_q.push_back(e);
  end

  always @(negedge clock) begin : scoreboard
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_src", 64'(src_sel), 64'(e.src));
      chk("sb_data", 64'({data1, data2, data3, data4, data5, data6}), 64'(e.data));
      chk("sb_hms", 64'({h, m, s}), 64'(e.hms));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
      @(negedge clock);
    end
  endtask

  initial begin
    cycles(3);
    chk("rst_src", 64'(src_sel), 64'd0);
    chk("rst_data", 64'({data1, data2, data3, data4, data5, data6}), 64'd0);
    chk("rst_hms", 64'({h, m, s}), 64'd0);
    reset = 1'b0;
    cycles(3);
    chk("clk_d1", 64'(data1), 64'(7'b0110000));
    chk("clk_d6", 64'(data6), 64'(7'b1011111));
    chk("clk_src", 64'(src_sel), 64'd0);

    // Alarm grant, whole display flashes.
    alm_req = 1'b1;
    cycles(2);
    chk("alm_src", 64'(src_sel), 64'd2);
    tick_n(255);
    chk("alm_flash", 64'({h, m, s}), 64'(3'b111));

    // Drop to clock: hold reloaded, timer must wait out the hold.
    alm_req = 1'b0;
    cycles(1);
    chk("drop_src", 64'(src_sel), 64'd0);
    tmr_req = 1'b1;
    tick_n(14);
    chk("hold_wait", 64'(src_sel), 64'd0);
    tick_n(1);
    cycles(2);
    chk("tmr_src", 64'(src_sel), 64'd1);
    chk("tmr_d4", 64'(data4), 64'(7'b1111011));

    alm_req = 1'b1;
    cycles(1);
    chk("preempt", 64'(src_sel), 64'd2);
    alm_req = 1'b0;
    cycles(1);
    chk("back_tmr", 64'(src_sel), 64'd1);
    tmr_req = 1'b0;
    cycles(1);
    chk("back_clk", 64'(src_sel), 64'd0);

    // Edit blinking on the clock source.
    edit_field = 2'd2;
    cycles(2);
    chk("edit_vis", 64'({h, m, s}), 64'(3'b000));
    tick_n(255);
    chk("edit_m", 64'({h, m, s}), 64'(3'b010));
    edit_field = 2'd3;
    cycles(1);
    chk("edit_clr", 64'({h, m, s}), 64'(3'b000));
    tick_n(260);
    edit_field = 2'd1;
    tick_n(20);
    edit_field = 2'd0;
    cycles(4);

    // Out-of-range digits and leading-zero handling.
    clk_bcd = 24'hA2F000;
    cycles(2);
    chk("dash_d1", 64'(data1), 64'(7'b0000001));
    chk("dash_d3", 64'(data3), 64'(7'b0000001));
    clk_bcd = 24'h012345;
    cycles(2);
`ifdef SEG_SCHED_LZB_EN
    chk("lzb_d1", 64'(data1), 64'(7'b0000000));
`else
    chk("lzb_d1", 64'(data1), 64'(7'b1111110));
`endif

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 2) alm_req = ~alm_req;
      if ($urandom_range(0, 99) < 4) tmr_req = ~tmr_req;
      if ($urandom_range(0, 99) < 1) edit_field = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 3) clk_bcd = 24'($urandom);
      if ($urandom_range(0, 99) < 3) tmr_bcd = 24'($urandom);
      if ($urandom_range(0, 99) < 3) alm_bcd = 24'($urandom);
      tick = ($urandom_range(0, 1) == 1);
      cycles(1);
    end
    tick = 1'b0;

    // Reset in the middle of an alarm flash.
    alm_req = 1'b0;
    tmr_req = 1'b0;
    cycles(2);
    alm_req = 1'b1;
    cycles(1);
    tick_n(252);
    chk("pre_rst_h", 64'(h), 64'd1);
    reset = 1'b1;
    tick = 1'b1;
    cycles(1);
    chk("mid_rst_src", 64'(src_sel), 64'd0);
    chk("mid_rst_data", 64'({data1, data2, data3, data4, data5, data6}), 64'd0);
    chk("mid_rst_hms", 64'({h, m, s}), 64'd0);
    tick = 1'b0;
    alm_req = 1'b0;
    cycles(1);
    reset = 1'b0;
    cycles(3);
    chk("post_rst_src", 64'(src_sel), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
